// File: rtl/dram_ctrl_pkg.sv
// Shared types and pin encodings for the DRAM command controller.
package dram_ctrl_pkg;

    localparam int unsigned ROW_W = 11;
    localparam int unsigned COL_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StPreWait,
        StAct,
        StActWait,
        StCol,
        StRdWait,
        StWrWait
    } state_e;

    typedef struct packed {
        logic       csn;
        logic       rasn;
        logic       casn;
        logic [3:0] wen;
    } cmd_t;

    localparam cmd_t CMD_NOP  = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam cmd_t CMD_ACT  = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
    localparam cmd_t CMD_PRE  = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
    localparam cmd_t CMD_READ = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};

    function automatic cmd_t cmd_write(input logic [3:0] wstrb);
        return '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: ~wstrb};
    endfunction

endpackage

// File: rtl/dram_cmd_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval.
module dram_cmd_timer #(
    parameter int unsigned CntW = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The load cycle itself counts, so an interval of N ends when the count reaches 1.
    assign done_o = (cnt_q <= CntW'(1));

endmodule

// File: rtl/dram_ctrl.sv
// Open-row DRAM command controller: single-beat requests to ACT/PRE/READ/WRITE pin sequences.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned T_RCD  = 5,
    parameter int unsigned T_RP   = 5,
    parameter int unsigned T_WR   = 3
) (
    input  logic              dram_clk,
    input  logic              dram_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_wstrb,
    input  logic [31:0]       req_wdata,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              wr_done,
    output logic              DRAM_CSn,
    output logic              DRAM_RASn,
    output logic              DRAM_CASn,
    output logic [3:0]        DRAM_WEn,
    output logic [10:0]       DRAM_A,
    output logic [31:0]       DRAM_D,
    input  logic [31:0]       DRAM_Q,
    input  logic              DRAM_VALID
);

    localparam int unsigned TMax = (T_RCD > T_RP) ? ((T_RCD > T_WR) ? T_RCD : T_WR)
                                                  : ((T_RP > T_WR) ? T_RP : T_WR);
    localparam int unsigned CntW = $clog2(TMax + 1);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                row_open_q, row_open_d;
    logic [ROW_W-1:0]    open_row_q, open_row_d;
    cmd_t                cmd_q, cmd_d;
    logic [10:0]         a_q, a_d;
    logic [31:0]         d_q, d_d;
    logic                rd_valid_q, rd_valid_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                wr_done_q, wr_done_d;
    logic                ready_q, ready_d;

    logic                tmr_load, tmr_done;
    logic [CntW-1:0]     tmr_val;
    logic                go_pre, go_act, go_col;

    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [3:0]          cur_wstrb;
    logic [31:0]         cur_wdata;
    logic [ROW_W-1:0]    cur_row;
    logic [COL_W-1:0]    cur_col;

    dram_cmd_timer #(
        .CntW (CntW)
    ) u_timer (
        .clk_i      (dram_clk),
        .rst_i      (dram_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // In the acceptance cycle the command is built from the live request, not the latch.
    always_comb begin
        cur_write = (state_q == StIdle) ? req_write : wr_q;
        cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
        cur_wstrb = (state_q == StIdle) ? req_wstrb : wstrb_q;
        cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
        cur_row   = cur_addr[COL_W +: ROW_W];
        cur_col   = cur_addr[COL_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        cmd_d      = CMD_NOP;
        a_d        = a_q;
        d_d        = d_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_done_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        go_pre     = 1'b0;
        go_act     = 1'b0;
        go_col     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    if (row_open_q && (open_row_q == cur_row)) begin
                        go_col = 1'b1;
                    end else if (row_open_q) begin
                        go_pre = 1'b1;
                    end else begin
                        go_act = 1'b1;
                    end
                end
            end
            StPre, StPreWait: begin
                if (tmr_done) go_act = 1'b1;
                else          state_d = StPreWait;
            end
            StAct, StActWait: begin
                if (tmr_done) go_col = 1'b1;
                else          state_d = StActWait;
            end
            StCol, StWrWait: begin
                if (!wr_q) begin
                    state_d = StRdWait;
                end else if (tmr_done) begin
                    state_d   = StIdle;
                    wr_done_d = 1'b1;
                end else begin
                    state_d = StWrWait;
                end
            end
            StRdWait: begin
                if (DRAM_VALID) begin
                    state_d    = StIdle;
                    rd_data_d  = DRAM_Q;
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_pre) begin
            state_d    = StPre;
            cmd_d      = CMD_PRE;
            row_open_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = CntW'(T_RP);
        end
        if (go_act) begin
            state_d    = StAct;
            cmd_d      = CMD_ACT;
            a_d        = cur_row;
            row_open_d = 1'b1;
            open_row_d = cur_row;
            tmr_load   = 1'b1;
            tmr_val    = CntW'(T_RCD);
        end
        if (go_col) begin
            state_d  = StCol;
            a_d      = {1'b0, cur_col};
            tmr_load = 1'b1;
            tmr_val  = CntW'(T_WR);
            if (cur_write) begin
                cmd_d = cmd_write(cur_wstrb);
                d_d   = cur_wdata;
            end else begin
                cmd_d = CMD_READ;
            end
        end

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            row_open_q <= 1'b0;
            open_row_q <= '0;
            cmd_q      <= CMD_NOP;
            a_q        <= '0;
            d_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_done_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            row_open_q <= row_open_d;
            open_row_q <= open_row_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            d_q        <= d_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            wr_done_q  <= wr_done_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_done   = wr_done_q;
    assign DRAM_CSn  = cmd_q.csn;
    assign DRAM_RASn = cmd_q.rasn;
    assign DRAM_CASn = cmd_q.casn;
    assign DRAM_WEn  = cmd_q.wen;
    assign DRAM_A    = a_q;
    assign DRAM_D    = d_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: pin-level DRAM model, directed vector table, reset corner, random scoreboard.
module tb_dram_ctrl;

    localparam int T_RCD = 5;
    localparam int T_RP  = 5;
    localparam int T_WR  = 3;

    logic        dram_clk;
    logic        dram_rst;
    logic        req_valid, req_ready, req_write;
    logic [20:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rd_valid, wr_done;
    logic [31:0] rd_data;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D, DRAM_Q;
    logic        DRAM_VALID;

    dram_ctrl #(
        .ADDR_W (21),
        .T_RCD  (T_RCD),
        .T_RP   (T_RP),
        .T_WR   (T_WR)
    ) dut (
        .dram_clk   (dram_clk),
        .dram_rst   (dram_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_done    (wr_done),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_Q     (DRAM_Q),
        .DRAM_VALID (DRAM_VALID)
    );

    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;

    int cyc = 0;
    always @(posedge dram_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Model and bench state
    logic [31:0] dram_mem [int];
    logic [31:0] ref_mem [int];
    logic [10:0] m_row = '0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    int          rd_key = 0;
    int          v_cyc = -100;
    logic        cur_wr = 1'b0;
    logic        noise = 1'b0;
    int          lat = 0;
    logic [31:0] last_rd = '0;

    int          r_pre, r_act, r_col, r_done, r_kind, r_vrel;
    logic [10:0] r_aact, r_acol;
    logic [3:0]  r_wen;
    logic [31:0] r_d, r_rdata;
    logic        r_ready_bad, r_extra;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = nw[b*8 +: 8];
        return v;
    endfunction

    function automatic logic [31:0] dram_get(input int k);
        if (dram_mem.exists(k)) return dram_mem[k];
        return 32'h5A5A_0000 | k;
    endfunction

    function automatic logic [31:0] ref_get(input int k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return 32'h5A5A_0000 | k;
    endfunction

    // DRAM pin model: decodes commands mid-cycle, answers reads 1..3 cycles after READ.
    initial begin
        int k;
        DRAM_VALID = 1'b0;
        DRAM_Q     = '0;
        forever begin
            @(negedge dram_clk);
            DRAM_VALID = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    DRAM_VALID = 1'b1;
                    DRAM_Q     = dram_get(rd_key);
                    rd_pend    = 1'b0;
                    v_cyc      = cyc;
                end else begin
                    rd_cnt--;
                end
            end else if (noise) begin
                DRAM_VALID = 1'b1;
                DRAM_Q     = 32'hBAD0_BAD0;
            end
            if (DRAM_CSn === 1'b0) begin
                k = int'({m_row, DRAM_A[9:0]});
                if (DRAM_RASn === 1'b0 && DRAM_CASn === 1'b1 && DRAM_WEn === 4'hF) begin
                    m_row = DRAM_A;
                end else if (DRAM_RASn === 1'b1 && DRAM_CASn === 1'b0) begin
                    if (cur_wr) begin
                        dram_mem[k] = merge(dram_get(k), DRAM_D, ~DRAM_WEn);
                    end else begin
                        rd_pend = 1'b1;
                        rd_cnt  = lat;
                        rd_key  = k;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge dram_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Issue one request and record pin commands (cycles relative to acceptance) until completion.
    task automatic run_txn(input logic wr, input logic [20:0] addr, input logic [3:0] strb,
                           input logic [31:0] wd);
        int n;
        int rel;
        r_pre = -1; r_act = -1; r_col = -1; r_done = -1; r_kind = 0; r_vrel = -100;
        r_aact = '0; r_acol = '0; r_wen = '0; r_d = '0; r_rdata = '0;
        r_ready_bad = 1'b0; r_extra = 1'b0;
        cur_wr    = wr;
        req_write = wr;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int k = 0; k < 64 && !req_ready; k++) step();
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        n = cyc;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            rel = cyc - n;
            if (DRAM_CSn === 1'b0) begin
                if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin
                    if (r_act >= 0) r_extra = 1'b1;
                    r_act  = rel;
                    r_aact = DRAM_A;
                end else if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) begin
                    if (r_pre >= 0) r_extra = 1'b1;
                    r_pre = rel;
                end else if (DRAM_RASn && !DRAM_CASn) begin
                    if (r_col >= 0) r_extra = 1'b1;
                    r_col  = rel;
                    r_acol = DRAM_A;
                    r_wen  = DRAM_WEn;
                    r_d    = DRAM_D;
                end else begin
                    r_extra = 1'b1;
                end
            end
            if (rd_valid || wr_done) begin
                r_done  = rel;
                r_kind  = (rd_valid && wr_done) ? 3 : (wr_done ? 1 : 2);
                r_rdata = rd_data;
                r_vrel  = v_cyc - n;
                if (!req_ready) r_ready_bad = 1'b1;
                break;
            end
            if (req_ready) r_ready_bad = 1'b1;
            step();
        end
    endtask

    task automatic check_txn(input string tag, input logic wr, input int e_pre, input int e_act,
                             input logic [10:0] e_aact, input int e_col, input logic [10:0] e_acol,
                             input logic [3:0] e_wen, input logic [31:0] e_data);
        chk($sformatf("%s kind", tag), r_kind, wr ? 1 : 2);
        chk($sformatf("%s pre cycle", tag), r_pre, e_pre);
        chk($sformatf("%s act cycle", tag), r_act, e_act);
        if (e_act >= 0) chk($sformatf("%s act A", tag), {21'b0, r_aact}, {21'b0, e_aact});
        chk($sformatf("%s col cycle", tag), r_col, e_col);
        chk($sformatf("%s col A", tag), {21'b0, r_acol}, {21'b0, e_acol});
        chk($sformatf("%s WEn", tag), {28'b0, r_wen}, {28'b0, e_wen});
        if (wr) begin
            chk($sformatf("%s D", tag), r_d, e_data);
            chk($sformatf("%s wr_done cycle", tag), r_done, e_col + T_WR);
            chk($sformatf("%s rd_data held", tag), r_rdata, last_rd);
        end else begin
            chk($sformatf("%s rd_valid cycle", tag), r_done, r_vrel + 1);
            chk($sformatf("%s rd_data", tag), r_rdata, e_data);
        end
        chk($sformatf("%s ready outside idle", tag), {31'b0, r_ready_bad}, 0);
        chk($sformatf("%s extra command", tag), {31'b0, r_extra}, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [20:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        noise;
        int          e_pre;
        int          e_act;
        logic [10:0] e_aact;
        int          e_col;
        logic [10:0] e_acol;
        logic [3:0]  e_wen;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          seen_act;
        logic        bad;
        logic        t_open;
        logic [10:0] t_row;
        logic        wr;
        logic [10:0] rw;
        logic [9:0]  cl;
        logic [20:0] ad;
        logic [3:0]  st;
        logic [31:0] wd;
        int          e_pre, e_act, e_col;

        vecs[0] = '{1'b0, 21'h000400, 4'h0, 32'h0, 1'b0, -1, 1, 11'd1, 6, 11'd0, 4'hF,
                    32'hDEADBEEF};
        vecs[1] = '{1'b1, 21'h000401, 4'b0101, 32'h11223344, 1'b0, -1, -1, 11'd0, 1, 11'd1,
                    4'b1010, 32'h11223344};
        vecs[2] = '{1'b0, 21'h000401, 4'h0, 32'h0, 1'b0, -1, -1, 11'd0, 1, 11'd1, 4'hF,
                    32'hAA22CC44};
        vecs[3] = '{1'b0, 21'h000800, 4'h0, 32'h0, 1'b0, 1, 6, 11'd2, 11, 11'd0, 4'hF,
                    32'h5A5A0800};
        vecs[4] = '{1'b1, 21'h000802, 4'h0, 32'hFFFFFFFF, 1'b1, -1, -1, 11'd0, 1, 11'd2, 4'hF,
                    32'hFFFFFFFF};
        vecs[5] = '{1'b0, 21'h000802, 4'h0, 32'h0, 1'b0, -1, -1, 11'd0, 1, 11'd2, 4'hF,
                    32'h5A5A0802};
        vecs[6] = '{1'b1, 21'h0007FF, 4'hF, 32'hCAFEF00D, 1'b0, 1, 6, 11'd1, 11, 11'h3FF, 4'h0,
                    32'hCAFEF00D};
        vecs[7] = '{1'b0, 21'h0007FF, 4'h0, 32'h0, 1'b0, -1, -1, 11'd0, 1, 11'h3FF, 4'hF,
                    32'hCAFEF00D};

        dram_mem[32'h400] = 32'hDEADBEEF;
        ref_mem[32'h400]  = 32'hDEADBEEF;
        dram_mem[32'h401] = 32'hAABBCCDD;
        ref_mem[32'h401]  = 32'hAABBCCDD;

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wstrb = '0;
        req_wdata = '0;
        dram_rst  = 1'b1;
        repeat (3) step();
        dram_rst = 1'b0;
        step();

        chk("reset ctl pins", {22'b0, req_ready, rd_valid, wr_done, DRAM_CSn, DRAM_RASn,
                               DRAM_CASn, DRAM_WEn}, 32'h27F);
        chk("reset A", {21'b0, DRAM_A}, 32'h0);
        chk("reset D", DRAM_D, 32'h0);
        chk("reset rd_data", rd_data, 32'h0);

        for (int i = 0; i < 8; i++) begin
            noise = vecs[i].noise;
            lat   = i % 3;
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wd);
            noise = 1'b0;
            check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].e_pre, vecs[i].e_act,
                      vecs[i].e_aact, vecs[i].e_col, vecs[i].e_acol, vecs[i].e_wen,
                      vecs[i].e_data);
            if (vecs[i].wr) begin
                ref_mem[int'(vecs[i].addr)] = merge(ref_get(int'(vecs[i].addr)), vecs[i].wd,
                                                    vecs[i].strb);
            end else begin
                last_rd = vecs[i].e_data;
            end
        end

        // Reset while waiting out tRCD for row 3 (row 1 was open).
        cur_wr    = 1'b0;
        lat       = 0;
        req_write = 1'b0;
        req_addr  = 21'h000C00;
        req_valid = 1'b1;
        chk("rst seq ready before", {31'b0, req_ready}, 1);
        n0 = cyc;
        step();
        req_valid = 1'b0;
        seen_act  = -1;
        for (int k = 0; k < 7; k++) begin
            if (DRAM_CSn === 1'b0 && DRAM_RASn === 1'b0 && DRAM_WEn === 4'hF) seen_act = cyc - n0;
            step();
        end
        chk("rst seq act cycle", seen_act, 6);
        dram_rst = 1'b1;
        step();
        dram_rst = 1'b0;
        chk("rst seq pins/ready", {22'b0, req_ready, rd_valid, wr_done, DRAM_CSn, DRAM_RASn,
                                   DRAM_CASn, DRAM_WEn}, 32'h27F);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (rd_valid !== 1'b0 || DRAM_CSn !== 1'b1 || req_ready !== 1'b1) bad = 1'b1;
        end
        chk("rst seq quiet after", {31'b0, bad}, 0);
        chk("rst seq rd_data cleared", rd_data, 32'h0);
        last_rd = '0;
        lat     = 1;
        run_txn(1'b0, 21'h000400, 4'h0, 32'h0);
        check_txn("post-rst row1", 1'b0, -1, 1, 11'd1, 1 + T_RCD, 11'd0, 4'hF, 32'hDEADBEEF);
        last_rd = 32'hDEADBEEF;
        t_open  = 1'b1;
        t_row   = 11'd1;

        for (int i = 0; i < 100; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rw  = 11'($urandom_range(0, 3));
            cl  = 10'($urandom_range(0, 7));
            ad  = {rw, cl};
            st  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            lat = $urandom_range(0, 2);
            if (!t_open) begin
                e_pre = -1; e_act = 1; e_col = 1 + T_RCD;
            end else if (t_row == rw) begin
                e_pre = -1; e_act = -1; e_col = 1;
            end else begin
                e_pre = 1; e_act = 1 + T_RP; e_col = 1 + T_RP + T_RCD;
            end
            t_open = 1'b1;
            t_row  = rw;
            run_txn(wr, ad, st, wd);
            if (wr) begin
                check_txn($sformatf("rnd%0d wr", i), 1'b1, e_pre, e_act, rw, e_col, {1'b0, cl},
                          ~st, wd);
                ref_mem[int'(ad)] = merge(ref_get(int'(ad)), wd, st);
            end else begin
                check_txn($sformatf("rnd%0d rd", i), 1'b0, e_pre, e_act, rw, e_col, {1'b0, cl},
                          4'hF, ref_get(int'(ad)));
                last_rd = ref_get(int'(ad));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
